alu_shift_wb: RTL and testbench
===============================

# alu_shift_wb

Writeback collector for the shift ALU. Captures the 64-bit shift result, which appears on the result bus in the issue cycle, and the COASZP flags, which arrive on the retData bus one cycle later. It pairs the two into one writeback record and buffers records in a DEPTH-entry FIFO toward the register-file/flag write port, which can backpressure. It drops records on a thread exception flush and raises `stall` to the scheduler before the buffer can overflow.

## Interface
- `REG_WIDTH`, default `` `reg_addr_width ``: destination register tag width.
- `EXCEPT_WIDTH`, default 9: retData bus width; flags COASZP occupy bits [5:0].
- `DEPTH`, default 4: FIFO entries; must be a power of 2, at least 2.

Ports:
- `clk` in 1: the single clock; all state updates on its rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `except` in 1: exception flush strobe.
- `except_thread` in 1: thread being flushed.
- `in_en` in 1: a shift result is valid on `valRes` this cycle.
- `in_reg` in REG_WIDTH: destination register tag.
- `in_thread` in 1: thread of the op.
- `in_flag_wr` in 1: the op writes flags.
- `valRes` in 64: shift result, valid when `in_en`.
- `retData` in EXCEPT_WIDTH: flags for the op accepted on the previous cycle.
- `wb_ready` in 1: the write port accepts the head record.
- `wb_en` out 1: head record valid.
- `wb_reg` out REG_WIDTH: head record register tag.
- `wb_thread` out 1: head record thread.
- `wb_data` out 64: head record result.
- `wb_flags` out 6: head record COASZP flags.
- `wb_flag_en` out 1: head record writes flags.
- `stall` out 1: scheduler must not issue shifts next cycle.
- `count` out log2(DEPTH)+1: number of occupied FIFO slots.
- `ovf` out 1: sticky overflow error.

## Operation
- **Stage A (capture):** when `in_en` is high at a rising edge, latch `valRes`, `in_reg`, `in_thread` and `in_flag_wr`, and set A.valid. A.valid is cleared at the next edge unless a new `in_en` arrives.
- **Stage B (pair/push):** in any cycle where A.valid is high, the record {A fields, `retData[5:0]`} is written to the FIFO tail at the edge, with live=1. Flags are always sampled exactly one cycle after `in_en`.
- **FIFO:** circular buffer with rd/wr pointers that wrap modulo DEPTH, plus a per-entry live bit. The head is the oldest entry.
- **Pop:**
  - Head live and `wb_ready` high: pop, and `wb_en` is high.
  - Head not live (killed): pop unconditionally with `wb_en` low, independent of `wb_ready`.
  - A push and a pop in the same cycle leave `count` unchanged.
- **Flush:** `except` high in a cycle kills everything with thread == `except_thread`:
  - A.valid entry is cleared (not pushed).
  - `in_en` in the same cycle is ignored.
  - Every matching FIFO entry has live cleared; killed entries still occupy slots until popped.
  - `wb_en` is gated combinationally: `wb_en` = head valid & head live & ~(`except` & `except_thread` == `wb_thread`).
  - The other thread is unaffected.
- **stall** = (`count` + A.valid) ≥ DEPTH−1, combinational.
- **Overflow:** a push with `count` == DEPTH and no simultaneous pop drops the record and sets `ovf`. `ovf` clears only on `rst`.
- **Reset:** clears A.valid, all live/valid bits and both pointers. After reset, `count`=0, `wb_en`=0, `stall`=0, `ovf`=0. Reset overrides all same-cycle activity.

## Timing
- `in_en` in cycle N: A.valid in N+1, flags sampled in N+1, record at the FIFO head and `wb_en` high in N+2 if the FIFO was empty. Latency is 2 cycles.
- Throughput is 1 record/cycle with `wb_ready` held high.
- `wb_*` outputs come directly from registered FIFO head state, except the combinational flush gate on `wb_en`.
- `stall` asserted in cycle N must stop `in_en` from N+1. The one in-flight A entry is covered by the DEPTH−1 threshold.
- Back-to-back `in_en` for different threads: flags always pair with the immediately preceding capture; there is no reordering.

## Test plan
- **Single op:** reset, then `in_en` with `valRes`=64'h0123_4567_89AB_CDEF, reg 5, thread 0, flag_wr 1, and `retData[5:0]`=6'b100010 next cycle, `wb_ready`=1 → exactly one `wb_en` pulse 2 cycles later with the same data, reg 5, flags 6'b100010, `wb_flag_en`=1.
- **Backpressure:** hold `wb_ready`=0 and issue 4 ops on consecutive cycles while obeying `stall` → `stall` rises when `count`+A.valid reaches 3, issue halts, `count` tops out ≤4. Release `wb_ready` → records drain in order, one per cycle.
- **Flush:** 3 entries buffered (threads 0,1,0) and an A entry for thread 0, then `except`=1, `except_thread`=0 → only the thread-1 record ever produces `wb_en`. Killed slots drain with `wb_en`=0 and `count` returns to 0.
- **Same-cycle flush and head:** thread-1 head presented with `wb_ready`=1 and `except_thread`=1 in the same cycle → `wb_en`=0 that cycle and the record never appears.
- **Overflow:** ignore `stall` and push 6 ops with `wb_ready`=0 → `ovf`=1 sticky, the first 4 records intact and the extras dropped. `rst` → `ovf`=0.
- **Reset mid-stream:** assert `rst` with 2 entries and A.valid → next cycle `wb_en`=0, `count`=0, `stall`=0, and no stale record appears afterwards.

Source files
------------

// File: rtl/alu_shift_wb.sv
// alu_shift_wb -- writeback collector for the shift ALU.
//
// Pairs each 64-bit shift result with the COASZP flags that follow it one
// cycle later on retData. Each pair becomes one writeback record, and the
// records are buffered in a DEPTH-entry FIFO in front of the register-file
// and flag write port. Records belonging to a flushed thread are killed in
// place. The scheduler is stalled before the buffer can overflow.
//
// Ports:
//   clk, rst           clock; synchronous active-high reset
//   except             exception flush strobe
//   except_thread      thread being flushed
//   in_en              shift result valid this cycle
//   in_reg             destination register tag
//   in_thread          thread of the op
//   in_flag_wr         op writes flags
//   valRes             64-bit shift result
//   retData            flags (bits [5:0]) for the op captured last cycle
//   wb_ready           write port accepts the head record
//   wb_en              head record valid and live
//   wb_reg             head record register tag
//   wb_thread          head record thread
//   wb_data            head record result
//   wb_flags           head record COASZP flags
//   wb_flag_en         head record writes flags
//   stall              scheduler must not issue shifts next cycle
//   count              occupied FIFO slots
//   ovf                sticky overflow error
`ifndef REG_ADDR_WIDTH
`define REG_ADDR_WIDTH 6
`endif

module alu_shift_wb #(
    parameter int REG_WIDTH    = `REG_ADDR_WIDTH,
    parameter int EXCEPT_WIDTH = 9,
    parameter int DEPTH        = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     except,
    input  logic                     except_thread,
    input  logic                     in_en,
    input  logic [REG_WIDTH-1:0]     in_reg,
    input  logic                     in_thread,
    input  logic                     in_flag_wr,
    input  logic [63:0]              valRes,
    input  logic [EXCEPT_WIDTH-1:0]  retData,
    input  logic                     wb_ready,
    output logic                     wb_en,
    output logic [REG_WIDTH-1:0]     wb_reg,
    output logic                     wb_thread,
    output logic [63:0]              wb_data,
    output logic [5:0]               wb_flags,
    output logic                     wb_flag_en,
    output logic                     stall,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     ovf
);
    localparam int AW      = $clog2(DEPTH);
    localparam int CW      = AW + 1;
    localparam int DEPTH_I = DEPTH;
    localparam int STH_I   = DEPTH - 1;
    localparam logic [CW-1:0] FULL     = DEPTH_I[CW-1:0];
    localparam logic [CW:0]   STALL_TH = STH_I[CW:0];

    // Stage A: capture register
    logic                 a_vld_q, a_vld_d;
    logic [63:0]          a_data_q;
    logic [REG_WIDTH-1:0] a_reg_q;
    logic                 a_thr_q;
    logic                 a_fwr_q;

    // FIFO storage and control
    logic [63:0]          fifo_data_q  [DEPTH];
    logic [REG_WIDTH-1:0] fifo_reg_q   [DEPTH];
    logic [5:0]           fifo_flags_q [DEPTH];
    logic [DEPTH-1:0]     fifo_thr_q;
    logic [DEPTH-1:0]     fifo_fen_q;
    logic [DEPTH-1:0]     live_q, live_d;
    logic [AW-1:0]        rd_q, rd_d;
    logic [AW-1:0]        wr_q, wr_d;
    logic [CW-1:0]        count_q, count_d;
    logic                 ovf_q, ovf_d;

    logic kill_a, push, push_ok, pop, head_vld, head_live, head_kill, full;

    // Only the flag bits of retData are consumed.
    logic unused_ret;
    assign unused_ret = ^retData;

    always_comb begin
        // A capture of the flushed thread is dropped, both the one already
        // in stage A and any arriving in the flush cycle.
        a_vld_d   = in_en & ~(except & (except_thread == in_thread));
        kill_a    = except & (except_thread == a_thr_q);
        push      = a_vld_q & ~kill_a;

        head_vld  = (count_q != '0);
        head_live = live_q[rd_q];
        head_kill = except & (except_thread == fifo_thr_q[rd_q]);
        // Killed heads drain without waiting for the write port.
        pop       = head_vld & (~head_live | wb_ready);

        full      = (count_q == FULL);
        push_ok   = push & (~full | pop);
        ovf_d     = ovf_q | (push & full & ~pop);

        rd_d      = pop     ? rd_q + AW'(1) : rd_q;
        wr_d      = push_ok ? wr_q + AW'(1) : wr_q;

        count_d   = count_q;
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        live_d = live_q;
        for (int i = 0; i < DEPTH; i++) begin
            if (except && (fifo_thr_q[i] == except_thread)) begin
                live_d[i] = 1'b0;
            end
        end
        if (pop) begin
            live_d[rd_q] = 1'b0;
        end
        // A pushed record never belongs to the flushed thread, so setting it
        // after the flush clear cannot resurrect a killed record.
        if (push_ok) begin
            live_d[wr_q] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_vld_q <= 1'b0;
            live_q  <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            a_vld_q <= a_vld_d;
            live_q  <= live_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    // Data paths carry no reset; the valid/live bits qualify them.
    always_ff @(posedge clk) begin
        if (in_en) begin
            a_data_q <= valRes;
            a_reg_q  <= in_reg;
            a_thr_q  <= in_thread;
            a_fwr_q  <= in_flag_wr;
        end
    end

    // Stage B: pair A with the flags arriving this cycle and push
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_data_q[wr_q]  <= a_data_q;
            fifo_reg_q[wr_q]   <= a_reg_q;
            fifo_flags_q[wr_q] <= retData[5:0];
            fifo_thr_q[wr_q]   <= a_thr_q;
            fifo_fen_q[wr_q]   <= a_fwr_q;
        end
    end

    // Head outputs straight from registered state; only wb_en sees the
    // same-cycle flush so a dying record is never written back.
    assign wb_en      = head_vld & head_live & ~head_kill;
    assign wb_reg     = fifo_reg_q[rd_q];
    assign wb_thread  = fifo_thr_q[rd_q];
    assign wb_data    = fifo_data_q[rd_q];
    assign wb_flags   = fifo_flags_q[rd_q];
    assign wb_flag_en = fifo_fen_q[rd_q];

    // The in-flight A entry is counted so one more capture always fits.
    assign stall = (({1'b0, count_q} + {{CW{1'b0}}, a_vld_q}) >= STALL_TH);
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_alu_shift_wb.sv
module tb_alu_shift_wb;
    localparam int RW    = 6;
    localparam int EW    = 9;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst, except, except_thread, in_en, in_thread, in_flag_wr, wb_ready;
    logic [RW-1:0] in_reg;
    logic [63:0]   valRes;
    logic [EW-1:0] retData;
    logic          wb_en, wb_thread, wb_flag_en, stall, ovf;
    logic [RW-1:0] wb_reg;
    logic [63:0]   wb_data;
    logic [5:0]    wb_flags;
    logic [2:0]    count;

    always #5 clk = ~clk;

    alu_shift_wb #(.REG_WIDTH(RW), .EXCEPT_WIDTH(EW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .except(except), .except_thread(except_thread),
        .in_en(in_en), .in_reg(in_reg), .in_thread(in_thread), .in_flag_wr(in_flag_wr),
        .valRes(valRes), .retData(retData), .wb_ready(wb_ready),
        .wb_en(wb_en), .wb_reg(wb_reg), .wb_thread(wb_thread), .wb_data(wb_data),
        .wb_flags(wb_flags), .wb_flag_en(wb_flag_en), .stall(stall), .count(count), .ovf(ovf)
    );

    typedef struct packed {
        logic [RW-1:0] rg;
        logic          th;
        logic [63:0]   d;
        logic [5:0]    fl;
        logic          fen;
    } rec_t;

    rec_t       exp_q[$];
    rec_t       mon_act, mon_exp;
    int         nvec = 0;
    int         nerr = 0;
    logic [5:0] nxt_flags = 6'h00;
    int         issued;
    int         k;

    // Scoreboard monitor: every accepted writeback must match the oldest expected record.
    always @(negedge clk) begin
        if (!rst && wb_en && wb_ready) begin
            mon_act = {wb_reg, wb_thread, wb_data, wb_flags, wb_flag_en};
            nvec++;
            if (exp_q.size() == 0) begin
                nerr++;
                $display("FAIL wb_unexpected: got record %h, required no record", mon_act);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_act !== mon_exp) begin
                    nerr++;
                    $display("FAIL wb_record: got %h required %h", mon_act, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
        nvec++;
        if (act !== expv) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", nm, act, expv);
        end
    endtask

    // One clock cycle: drive the op (if any) and the flags of last cycle's op.
    task automatic cyc(input logic en, input logic [RW-1:0] rg, input logic th, input logic fw,
                       input logic [63:0] d, input logic [5:0] fl, input logic ex);
        in_en      = en;
        in_reg     = rg;
        in_thread  = th;
        in_flag_wr = fw;
        valRes     = d;
        retData    = {3'b000, nxt_flags};
        nxt_flags  = en ? fl : 6'h00;
        if (en && ex) exp_q.push_back({rg, th, d, fl, fw});
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, '0, 1'b0, 1'b0, 64'h0, 6'h00, 1'b0);
    endtask

    task automatic drain(input string nm);
        int n = 0;
        while ((exp_q.size() != 0 || count != 0) && n < 40) begin
            idle();
            n++;
        end
        chk(nm, count, 0);
        chk({nm, "_pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst = 1'b1; except = 1'b0; except_thread = 1'b0; in_en = 1'b0; in_reg = '0;
        in_thread = 1'b0; in_flag_wr = 1'b0; valRes = '0; retData = '0; wb_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_count", count, 0);
        chk("rst_wb_en", wb_en, 0);
        chk("rst_stall", stall, 0);
        chk("rst_ovf", ovf, 0);

        // Single op, 2-cycle latency
        cyc(1'b1, 6'd5, 1'b0, 1'b1, 64'h0123_4567_89AB_CDEF, 6'b100010, 1'b1);
        chk("single_wb_en_n1", wb_en, 0);
        chk("single_stall_n1", stall, 0);
        idle();
        chk("single_wb_en_n2", wb_en, 1);
        chk("single_count_n2", count, 1);
        idle();
        chk("single_wb_en_n3", wb_en, 0);
        chk("single_count_n3", count, 0);

        // Backpressure obeying stall, alternating threads
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("bp_nostall", stall, 0);
            cyc(1'b1, RW'(10 + i), i[0], ~i[0], {32'hCAFE_0000 + i, 32'h1234_0000 + i}, 6'(i * 9 + 3), 1'b1);
        end
        chk("bp_stall_rise", stall, 1);
        chk("bp_count_a", count, 2);
        idle();
        chk("bp_count_b", count, 3);
        chk("bp_stall_hold", stall, 1);
        idle();
        chk("bp_count_hold", count, 3);
        chk("bp_head_wb_en", wb_en, 1);
        wb_ready = 1'b1;
        issued = 3;
        k = 0;
        while (issued < 4 && k < 20) begin
            if (!stall) begin
                cyc(1'b1, 6'd13, 1'b1, 1'b0, 64'hCAFE_0003_1234_0003, 6'd30, 1'b1);
                issued++;
            end else begin
                idle();
            end
            k++;
        end
        chk("bp_issue_4", issued, 4);
        drain("bp_drain");

        // Flush thread 0 with three buffered records and an A entry
        wb_ready = 1'b0;
        cyc(1'b1, 6'd20, 1'b0, 1'b1, 64'hAAAA_0000_0000_0020, 6'h11, 1'b0);
        cyc(1'b1, 6'd21, 1'b1, 1'b1, 64'hBBBB_0000_0000_0021, 6'h2A, 1'b1);
        cyc(1'b1, 6'd22, 1'b0, 1'b0, 64'hAAAA_0000_0000_0022, 6'h15, 1'b0);
        cyc(1'b1, 6'd23, 1'b0, 1'b1, 64'hAAAA_0000_0000_0023, 6'h3F, 1'b0);
        chk("fl_count_pre", count, 3);
        except = 1'b1;
        except_thread = 1'b0;
        idle();
        except = 1'b0;
        chk("fl_count_post", count, 3);
        chk("fl_head_dead", wb_en, 0);
        wb_ready = 1'b1;
        drain("fl_drain");

        // Same-cycle flush of a live thread-1 head
        cyc(1'b1, 6'd30, 1'b1, 1'b1, 64'hDEAD_BEEF_0000_0030, 6'h07, 1'b0);
        idle();
        except = 1'b1;
        except_thread = 1'b1;
        #1;
        chk("sc_wb_en_gated", wb_en, 0);
        idle();
        except = 1'b0;
        drain("sc_drain");

        // Overflow: ignore stall, 6 ops into a 4-deep buffer
        wb_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc(1'b1, RW'(40 + i), i[1], i[0], {32'h0F0F_0000 + i, 32'h5A5A_0000 + i}, 6'(i * 7 + 1), (i < 4));
        end
        idle();
        chk("ovf_set", ovf, 1);
        chk("ovf_count", count, 4);
        idle();
        chk("ovf_sticky", ovf, 1);
        wb_ready = 1'b1;
        drain("ovf_drain");
        chk("ovf_sticky_after_drain", ovf, 1);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("ovf_rst", ovf, 0);

        // Reset mid-stream with two entries and an A entry
        wb_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, RW'(50 + i), 1'b0, 1'b1, 64'h7777_0000_0000_0000 + 64'(i), 6'h21, 1'b0);
        end
        chk("mr_count_pre", count, 2);
        rst = 1'b1;
        idle();
        rst = 1'b0;
        chk("mr_wb_en", wb_en, 0);
        chk("mr_count", count, 0);
        chk("mr_stall", stall, 0);
        wb_ready = 1'b1;
        repeat (4) idle();
        chk("mr_count_later", count, 0);

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
